// File: rtl/temp_ctrl_pkg.sv
// Shared types and constants for the temperature display update sequencer.
// Holds the FSM state encoding, datapath widths and the BCD add-3 helper.
package temp_ctrl_pkg;

    localparam int TC_W     = 13;
    localparam int MAG_W    = 13;
    localparam int BCD_W    = 16;
    localparam int BCD_ITER = 13;

    localparam logic [3:0] BLANK_DIGIT = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        CONVERT,
        LOAD,
        GAP
    } state_e;

    // Double-dabble correction: any nibble of 5 or more gets 3 added before the shift.
    function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] acc);
        logic [BCD_W-1:0] res;
        res = acc;
        for (int n = 0; n < BCD_W / 4; n++) begin
            if (acc[4*n +: 4] >= 4'd5) begin
                res[4*n +: 4] = acc[4*n +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/temp_update_ctrl_bcd_serial.sv
// Serial shift-add-3 binary to BCD converter, one bit per cycle.
// start_i loads the magnitude; done_o is high during the final iteration cycle.
module bcd_serial
    import temp_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [MAG_W-1:0] bin_i,
    output logic             done_o,
    output logic [BCD_W-1:0] bcd_o
);

    localparam int ITER_W = $clog2(BCD_ITER);
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(BCD_ITER - 1);

    logic [MAG_W-1:0]  shift_q, shift_d;
    logic [BCD_W-1:0]  acc_q, acc_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic              active_q, active_d;
    logic [BCD_W-1:0]  acc_adj;

    assign acc_adj = bcd_adjust(acc_q);

    always_comb begin
        shift_d  = shift_q;
        acc_d    = acc_q;
        iter_d   = iter_q;
        active_d = active_q;
        if (start_i) begin
            shift_d  = bin_i;
            acc_d    = '0;
            iter_d   = '0;
            active_d = 1'b1;
        end else if (active_q) begin
            acc_d   = {acc_adj[BCD_W-2:0], shift_q[MAG_W-1]};
            shift_d = {shift_q[MAG_W-2:0], 1'b0};
            iter_d  = iter_q + 1'b1;
            if (iter_q == ITER_LAST) begin
                active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q  <= '0;
            acc_q    <= '0;
            iter_q   <= '0;
            active_q <= 1'b0;
        end else begin
            shift_q  <= shift_d;
            acc_q    <= acc_d;
            iter_q   <= iter_d;
            active_q <= active_d;
        end
    end

    assign done_o = active_q && (iter_q == ITER_LAST);
    assign bcd_o  = acc_q;

endmodule

// File: rtl/temp_update_ctrl.sv
// Update sequencer for the temperature display: holds inputs, converts to BCD, publishes digits.
// Define TEMP_BLANK_LZ_EN to blank leading-zero digits above ones with BLANK_DIGIT.
module temp_update_ctrl
    import temp_ctrl_pkg::*;
#(
    parameter int SETTLE_CYC = 2,
    parameter int MIN_GAP    = 1000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [TC_W-1:0] tc,
    input  logic            tc_valid,
    input  logic            c_f,
    output logic [TC_W-1:0] tc_hold,
    output logic            cf_hold,
    input  logic            dp_sign,
    input  logic [MAG_W-1:0] dp_mag_r,
    output logic            sign,
    output logic [3:0]      ones,
    output logic [3:0]      tens,
    output logic [3:0]      hund,
    output logic [3:0]      thou,
    output logic            busy,
    output logic            upd_done
);

    localparam int GAP_W = $clog2(MIN_GAP + 1);
    localparam int SET_W = $clog2(SETTLE_CYC + 1);
    localparam logic [GAP_W-1:0] GAP_LOAD    = GAP_W'(MIN_GAP);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);

    state_e            state_q, state_d;
    logic [TC_W-1:0]   tc_stage_q, tc_stage_d;
    logic              stage_vld_q, stage_vld_d;
    logic              pending_q, pending_d;
    logic [TC_W-1:0]   tc_hold_q, tc_hold_d;
    logic              cf_hold_q, cf_hold_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [SET_W-1:0]  settle_q, settle_d;
    logic              sgn_q, sgn_d;
    logic              sign_q, sign_d;
    logic [3:0]        ones_q, ones_d;
    logic [3:0]        tens_q, tens_d;
    logic [3:0]        hund_q, hund_d;
    logic [3:0]        thou_q, thou_d;
    logic              upd_done_q, upd_done_d;

    logic              cf_change;
    logic              settle_last;
    logic              bcd_start;
    logic              bcd_done;
    logic [BCD_W-1:0]  bcd_val;

    assign cf_change   = (c_f != cf_hold_q);
    assign settle_last = (settle_q == SETTLE_LAST);
    assign bcd_start   = (state_q == SETTLE) && settle_last;

    bcd_serial u_bcd (
        .clk     (clk),
        .rst     (rst),
        .start_i (bcd_start),
        .bin_i   (dp_mag_r),
        .done_o  (bcd_done),
        .bcd_o   (bcd_val)
    );

    always_comb begin
        state_d     = state_q;
        tc_stage_d  = tc_stage_q;
        stage_vld_d = stage_vld_q;
        pending_d   = pending_q;
        tc_hold_d   = tc_hold_q;
        cf_hold_d   = cf_hold_q;
        gap_d       = (gap_q != '0) ? gap_q - 1'b1 : gap_q;
        settle_d    = settle_q;
        sgn_d       = sgn_q;
        sign_d      = sign_q;
        ones_d      = ones_q;
        tens_d      = tens_q;
        hund_d      = hund_q;
        thou_d      = thou_q;
        upd_done_d  = 1'b0;

        if (tc_valid) begin
            tc_stage_d  = tc;
            stage_vld_d = 1'b1;
            pending_d   = 1'b1;
        end
        if ((state_q != IDLE) && cf_change) begin
            pending_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                // A c_f change alone reuses the existing tc_hold sample.
                if (pending_q || tc_valid || cf_change) begin
                    if (tc_valid) begin
                        tc_hold_d = tc;
                    end else if (stage_vld_q) begin
                        tc_hold_d = tc_stage_q;
                    end
                    cf_hold_d   = c_f;
                    pending_d   = 1'b0;
                    stage_vld_d = 1'b0;
                    gap_d       = GAP_LOAD;
                    settle_d    = '0;
                    state_d     = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_last) begin
                    sgn_d   = dp_sign && (dp_mag_r != '0);
                    state_d = CONVERT;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            CONVERT: begin
                if (bcd_done) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                sign_d = sgn_q;
                ones_d = bcd_val[3:0];
`ifdef TEMP_BLANK_LZ_EN
                thou_d = (bcd_val[15:12] == 4'd0) ? BLANK_DIGIT : bcd_val[15:12];
                hund_d = (bcd_val[15:8]  == 8'd0) ? BLANK_DIGIT : bcd_val[11:8];
                tens_d = (bcd_val[15:4]  == 12'd0) ? BLANK_DIGIT : bcd_val[7:4];
`else
                thou_d = bcd_val[15:12];
                hund_d = bcd_val[11:8];
                tens_d = bcd_val[7:4];
`endif
                upd_done_d = 1'b1;
                state_d    = GAP;
            end
            GAP: begin
                if ((gap_q == '0) || (gap_q == GAP_W'(1))) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tc_stage_q  <= '0;
            stage_vld_q <= 1'b0;
            pending_q   <= 1'b0;
            tc_hold_q   <= '0;
            cf_hold_q   <= 1'b0;
            gap_q       <= '0;
            settle_q    <= '0;
            sgn_q       <= 1'b0;
            sign_q      <= 1'b0;
            ones_q      <= 4'd0;
            tens_q      <= 4'd0;
            hund_q      <= 4'd0;
            thou_q      <= 4'd0;
            upd_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tc_stage_q  <= tc_stage_d;
            stage_vld_q <= stage_vld_d;
            pending_q   <= pending_d;
            tc_hold_q   <= tc_hold_d;
            cf_hold_q   <= cf_hold_d;
            gap_q       <= gap_d;
            settle_q    <= settle_d;
            sgn_q       <= sgn_d;
            sign_q      <= sign_d;
            ones_q      <= ones_d;
            tens_q      <= tens_d;
            hund_q      <= hund_d;
            thou_q      <= thou_d;
            upd_done_q  <= upd_done_d;
        end
    end

    assign tc_hold  = tc_hold_q;
    assign cf_hold  = cf_hold_q;
    assign sign     = sign_q;
    assign ones     = ones_q;
    assign tens     = tens_q;
    assign hund     = hund_q;
    assign thou     = thou_q;
    assign busy     = (state_q != IDLE);
    assign upd_done = upd_done_q;

endmodule

// File: tb/tb_temp_update_ctrl.sv
// Self-checking bench for temp_update_ctrl with a behavioural convert/round datapath.
// Expected digits come from a vector table and a reference conversion model via a scoreboard.
module tb_temp_update_ctrl;

    localparam int SETTLE = 2;
    localparam int GAPCYC = 40;
    localparam int LAT    = SETTLE + 14;

    logic        clk = 1'b0;
    logic        rst;
    logic [12:0] tc;
    logic        tc_valid;
    logic        c_f;
    logic [12:0] tc_hold;
    logic        cf_hold;
    logic        dp_sign;
    logic [12:0] dp_mag_r;
    logic        sign;
    logic [3:0]  ones, tens, hund, thou;
    logic        busy;
    logic        upd_done;

    always #5 clk = ~clk;

    temp_update_ctrl #(
        .SETTLE_CYC (SETTLE),
        .MIN_GAP    (GAPCYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tc       (tc),
        .tc_valid (tc_valid),
        .c_f      (c_f),
        .tc_hold  (tc_hold),
        .cf_hold  (cf_hold),
        .dp_sign  (dp_sign),
        .dp_mag_r (dp_mag_r),
        .sign     (sign),
        .ones     (ones),
        .tens     (tens),
        .hund     (hund),
        .thou     (thou),
        .busy     (busy),
        .upd_done (upd_done)
    );

    // Datapath stand-in: tenths of a degree from a 1/16 C sample, or an override value.
    logic        ovrEn   = 1'b0;
    logic        ovrSign = 1'b0;
    logic [12:0] ovrMag  = 13'd0;
    int          dpV;
    int          dpA;

    always_comb begin
        dpV      = 0;
        dpA      = 0;
        dp_sign  = 1'b0;
        dp_mag_r = 13'd0;
        if (ovrEn) begin
            dp_sign  = ovrSign;
            dp_mag_r = ovrMag;
        end else begin
            dpV     = (cf_hold ? 9 : 5) * int'($signed(tc_hold)) + (cf_hold ? 2560 : 0);
            dp_sign = (dpV < 0);
            dpA     = ((dpV < 0) ? -dpV : dpV) + 4;
            dpA     = dpA / 8;
            if (dpA > 8191) dpA = 8191;
            dp_mag_r = 13'(dpA);
        end
    end

    typedef struct {
        string       name;
        logic [12:0] tc;
        logic        cf;
        logic        ovr;
        logic        ovrS;
        logic [12:0] ovrM;
        logic [16:0] exp;
    } vec_t;

    vec_t        vecs[10];
    logic [16:0] expQ[$];
    logic [16:0] sbExp;
    int          compared   = 0;
    int          mismatched = 0;
    int          updCount   = 0;

    function automatic logic [16:0] blankExp(input logic [16:0] e);
        logic [3:0] th, hu, te;
        th = e[15:12];
        hu = e[11:8];
        te = e[7:4];
`ifdef TEMP_BLANK_LZ_EN
        if (th == 4'd0) begin
            th = 4'hF;
            if (hu == 4'd0) begin
                hu = 4'hF;
                if (te == 4'd0) te = 4'hF;
            end
        end
`endif
        return {e[16], th, hu, te, e[3:0]};
    endfunction

    function automatic logic [16:0] refConvert(input logic [12:0] t, input logic cf,
                                               input logic ovr, input logic ovrS,
                                               input logic [12:0] ovrM);
        int   v, m;
        logic s;
        if (ovr) begin
            m = int'(ovrM);
            s = ovrS;
        end else begin
            v = (cf ? 9 : 5) * int'($signed(t)) + (cf ? 2560 : 0);
            s = (v < 0);
            m = (((v < 0) ? -v : v) + 4) / 8;
            if (m > 8191) m = 8191;
        end
        if (m == 0) s = 1'b0;
        return blankExp({s, 4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)});
    endfunction

    function automatic vec_t mkVec(input string n, input logic [12:0] t, input logic cf,
                                   input logic ovr, input logic ovrS, input logic [12:0] ovrM,
                                   input logic [16:0] e);
        vec_t v;
        v.name = n; v.tc = t; v.cf = cf; v.ovr = ovr; v.ovrS = ovrS; v.ovrM = ovrM; v.exp = e;
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [12:0] t, input logic cf, input logic ovr,
                                 input logic ovrS, input logic [12:0] ovrM);
        ovrEn    = ovr;
        ovrSign  = ovrS;
        ovrMag   = ovrM;
        c_f      = cf;
        tc       = t;
        tc_valid = 1'b1;
        tick;
        tc_valid = 1'b0;
    endtask

    task automatic waitUpd(input int limit, output int cyc);
        cyc = 0;
        while (!upd_done && cyc < limit) begin
            tick;
            cyc++;
        end
        checkOutput("upd_done seen", 32'(upd_done), 32'd1);
    endtask

    task automatic waitIdle(input int limit, output int cyc);
        cyc = 0;
        while (busy && cyc < limit) begin
            tick;
            cyc++;
        end
        checkOutput("busy released", 32'(busy), 32'd0);
    endtask

    // Scoreboard: every published update pops one expected result.
    always @(negedge clk) begin
        if (!rst && upd_done) begin
            updCount++;
            if (expQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected upd_done: got digits 0x%0h, want no update",
                         {sign, thou, hund, tens, ones});
            end else begin
                sbExp = expQ.pop_front();
                checkOutput("scoreboard digits", 32'({sign, thou, hund, tens, ones}), 32'(sbExp));
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        int startCnt;

        vecs[0] = mkVec("basic 400C",   13'd400,     1'b0, 1'b0, 1'b0, 13'd0,    {1'b0, 4'd0, 4'd2, 4'd5, 4'd0});
        vecs[1] = mkVec("neg -120C",    13'(-120),   1'b0, 1'b0, 1'b0, 13'd0,    {1'b1, 4'd0, 4'd0, 4'd7, 4'd5});
        vecs[2] = mkVec("minus zero",   13'd7,       1'b0, 1'b1, 1'b1, 13'd0,    {1'b0, 4'd0, 4'd0, 4'd0, 4'd0});
        vecs[3] = mkVec("full scale",   13'd9,       1'b0, 1'b1, 1'b0, 13'd8191, {1'b0, 4'd8, 4'd1, 4'd9, 4'd1});
        vecs[4] = mkVec("400 in F",     13'd400,     1'b1, 1'b0, 1'b0, 13'd0,    {1'b0, 4'd0, 4'd7, 4'd7, 4'd0});
        vecs[5] = mkVec("-800 in F",    13'(-800),   1'b1, 1'b0, 1'b0, 13'd0,    {1'b1, 4'd0, 4'd5, 4'd8, 4'd0});
        vecs[6] = mkVec("one lsb",      13'd1,       1'b0, 1'b0, 1'b0, 13'd0,    {1'b0, 4'd0, 4'd0, 4'd0, 4'd1});
        vecs[7] = mkVec("mag 5",        13'd3,       1'b0, 1'b1, 1'b0, 13'd5,    {1'b0, 4'd0, 4'd0, 4'd0, 4'd5});
        vecs[8] = mkVec("most neg",     13'(-4096),  1'b0, 1'b0, 1'b0, 13'd0,    {1'b1, 4'd2, 4'd5, 4'd6, 4'd0});
        vecs[9] = mkVec("neg 1000",     13'd11,      1'b0, 1'b1, 1'b1, 13'd1000, {1'b1, 4'd1, 4'd0, 4'd0, 4'd0});

        rst      = 1'b1;
        tc       = 13'd0;
        tc_valid = 1'b0;
        c_f      = 1'b0;
        repeat (3) tick;
        checkOutput("reset tc_hold", 32'(tc_hold), 32'd0);
        checkOutput("reset cf_hold", 32'(cf_hold), 32'd0);
        checkOutput("reset digits", 32'({sign, thou, hund, tens, ones}), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset upd_done", 32'(upd_done), 32'd0);
        rst = 1'b0;
        tick;

        for (int i = 0; i < 10; i++) begin
            expQ.push_back(blankExp(vecs[i].exp));
            applyStimulus(vecs[i].tc, vecs[i].cf, vecs[i].ovr, vecs[i].ovrS, vecs[i].ovrM);
            waitUpd(LAT + 10, cyc);
            checkOutput({vecs[i].name, " latency"}, 32'(cyc), 32'(LAT));
            checkOutput({vecs[i].name, " tc_hold"}, 32'(tc_hold), 32'(vecs[i].tc));
            checkOutput({vecs[i].name, " cf_hold"}, 32'(cf_hold), 32'(vecs[i].cf));
            tick;
            checkOutput({vecs[i].name, " upd_done width"}, 32'(upd_done), 32'd0);
            waitIdle(GAPCYC + 10, cyc);
            checkOutput({vecs[i].name, " gap length"}, 32'(cyc + LAT + 1), 32'(GAPCYC));
        end

        // Back-to-back: three strobes, the last one wins the second update.
        startCnt = updCount;
        expQ.push_back(refConvert(13'd100, 1'b0, 1'b0, 1'b0, 13'd0));
        applyStimulus(13'd100, 1'b0, 1'b0, 1'b0, 13'd0);
        repeat (4) tick;
        tc = 13'd200; tc_valid = 1'b1; tick; tc_valid = 1'b0;
        repeat (3) tick;
        tc = 13'd300; tc_valid = 1'b1; tick; tc_valid = 1'b0;
        expQ.push_back(refConvert(13'd300, 1'b0, 1'b0, 1'b0, 13'd0));
        waitUpd(LAT + 10, cyc);
        checkOutput("b2b first tc_hold", 32'(tc_hold), 32'd100);
        tick;
        waitIdle(GAPCYC + 10, cyc);
        waitUpd(GAPCYC + LAT + 10, cyc);
        checkOutput("b2b second tc_hold", 32'(tc_hold), 32'd300);
        tick;
        waitIdle(GAPCYC + 10, cyc);
        repeat (30) tick;
        checkOutput("b2b update count", 32'(updCount - startCnt), 32'd2);

        // Unit toggle during CONVERT queues a second update with the new unit.
        expQ.push_back(refConvert(13'd240, 1'b0, 1'b0, 1'b0, 13'd0));
        applyStimulus(13'd240, 1'b0, 1'b0, 1'b0, 13'd0);
        repeat (6) tick;
        c_f = 1'b1;
        expQ.push_back(refConvert(13'd240, 1'b1, 1'b0, 1'b0, 13'd0));
        waitUpd(LAT + 10, cyc);
        checkOutput("toggle first cf_hold", 32'(cf_hold), 32'd0);
        checkOutput("toggle first tc_hold", 32'(tc_hold), 32'd240);
        tick;
        waitIdle(GAPCYC + 10, cyc);
        waitUpd(GAPCYC + LAT + 10, cyc);
        checkOutput("toggle second cf_hold", 32'(cf_hold), 32'd1);
        checkOutput("toggle second tc_hold", 32'(tc_hold), 32'd240);
        tick;
        waitIdle(GAPCYC + 10, cyc);

        // Reset mid-CONVERT: nothing from the partial conversion is published.
        applyStimulus(13'd400, 1'b0, 1'b0, 1'b0, 13'd0);
        repeat (8) tick;
        checkOutput("pre-reset busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checkOutput("mid reset tc_hold", 32'(tc_hold), 32'd0);
        checkOutput("mid reset cf_hold", 32'(cf_hold), 32'd0);
        checkOutput("mid reset digits", 32'({sign, thou, hund, tens, ones}), 32'd0);
        checkOutput("mid reset busy", 32'(busy), 32'd0);
        checkOutput("mid reset upd_done", 32'(upd_done), 32'd0);
        startCnt = updCount;
        repeat (40) tick;
        checkOutput("no update after reset", 32'(updCount - startCnt), 32'd0);

        expQ.push_back(refConvert(13'd0, 1'b0, 1'b1, 1'b0, 13'd8191));
        applyStimulus(13'd0, 1'b0, 1'b1, 1'b0, 13'd8191);
        waitUpd(LAT + 10, cyc);
        checkOutput("full scale after reset latency", 32'(cyc), 32'(LAT));
        tick;
        waitIdle(GAPCYC + 10, cyc);

        checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
